// File: rtl/trade_pkg.sv
// Shared types for the multi-channel mean-reversion engine: position encoding
// and the stage-1 band record handed from the band calculator to the FSM stage.
package trade_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CH_W   = $clog2(DEF_NUM_CH);

    typedef enum logic [1:0] {
        FLAT  = 2'd0,
        LONG  = 2'd1,
        SHORT = 2'd2
    } pos_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] mid;
        logic [DEF_DATA_W-1:0] upper;
        logic [DEF_DATA_W-1:0] lower;
        logic                  trend;
        logic [DEF_DATA_W-1:0] price;
        logic [DEF_CH_W-1:0]   ch;
        logic                  valid;
    } band_t;
endpackage

// File: rtl/trade_band_calc.sv
// Stage 1: registers the mean, the saturating entry band around it and the
// trend flag for one sample; out-of-range channels never become valid.
module trade_band_calc
    import trade_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] short_sma,
    input  logic [DATA_W-1:0] long_sma,
    input  logic [DATA_W-1:0] current_data,
    input  logic [DATA_W-1:0] entry_thresh,
    output band_t             band
);
    logic [DATA_W:0]   sma_sum;
    logic [DATA_W-1:0] mid;
    logic [DATA_W:0]   upper_sum;
    logic              ch_ok;

    assign sma_sum   = {1'b0, short_sma} + {1'b0, long_sma};
    assign mid       = sma_sum[DATA_W:1];
    // The extra carry bit tells us the upper bound overflowed and must clamp.
    assign upper_sum = {1'b0, mid} + {1'b0, entry_thresh};
    assign ch_ok     = int'(in_ch) < NUM_CH;

    always_ff @(posedge clk) begin
        if (rst) begin
            band <= '0;
        end else begin
            band.valid <= in_valid && ch_ok;
            band.ch    <= in_ch;
            band.price <= current_data;
            band.trend <= short_sma > long_sma;
            band.mid   <= mid;
            band.upper <= upper_sum[DATA_W] ? {DATA_W{1'b1}} : upper_sum[DATA_W-1:0];
            band.lower <= (mid > entry_thresh) ? (mid - entry_thresh) : '0;
        end
    end
endmodule

// File: rtl/trade_mean_rev_mc.sv
// Multi-channel mean-reversion signal engine: stage-1 band calculation, then a
// per-channel position FSM with post-exit cooldown producing buy/sell pulses.
module trade_mean_rev_mc
    import trade_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CH_W     = $clog2(NUM_CH),
    parameter int COOLDOWN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] short_sma,
    input  logic [DATA_W-1:0] long_sma,
    input  logic [DATA_W-1:0] current_data,
    input  logic [DATA_W-1:0] entry_thresh,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic              buy_signal,
    output logic              sell_signal,
    output logic [1:0]        pos_state
);
    // Handshake: in_valid qualifies a sample and there is no ready, so one sample
    // is taken every cycle; out_valid qualifies out_ch/buy/sell/pos_state for
    // exactly one cycle, two cycles after the sample was presented.
    localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    band_t           band;
    pos_t            pos_q [NUM_CH];
    logic [CD_W-1:0] cd_q  [NUM_CH];
    pos_t            cur_pos, nxt_pos;
    logic [CD_W-1:0] cur_cd, nxt_cd;
    logic            nxt_buy, nxt_sell;

    trade_band_calc #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_band (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ch        (in_ch),
        .short_sma    (short_sma),
        .long_sma     (long_sma),
        .current_data (current_data),
        .entry_thresh (entry_thresh),
        .band         (band)
    );

    assign cur_pos = pos_q[band.ch];
    assign cur_cd  = cd_q[band.ch];

    always_comb begin
        nxt_pos  = cur_pos;
        nxt_cd   = cur_cd;
        nxt_buy  = 1'b0;
        nxt_sell = 1'b0;
        case (cur_pos)
            FLAT: begin
                // A blocked sample only counts down; the one reaching zero stays blocked.
                if (cur_cd != '0) begin
                    nxt_cd = cur_cd - CD_W'(1);
                end else if (band.trend && (band.price < band.lower)) begin
                    nxt_pos = LONG;
                    nxt_buy = 1'b1;
                end else if (!band.trend && (band.price > band.upper)) begin
                    nxt_pos  = SHORT;
                    nxt_sell = 1'b1;
                end
            end
            LONG: begin
                if (band.price >= band.mid) begin
                    nxt_pos  = FLAT;
                    nxt_sell = 1'b1;
                    nxt_cd   = CD_W'(COOLDOWN);
                end
            end
            SHORT: begin
                if (band.price <= band.mid) begin
                    nxt_pos = FLAT;
                    nxt_buy = 1'b1;
                    nxt_cd  = CD_W'(COOLDOWN);
                end
            end
            default: nxt_pos = FLAT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pos_q[i] <= FLAT;
                cd_q[i]  <= '0;
            end
            out_valid   <= 1'b0;
            out_ch      <= '0;
            buy_signal  <= 1'b0;
            sell_signal <= 1'b0;
            pos_state   <= 2'd0;
        end else begin
            out_valid   <= band.valid;
            buy_signal  <= band.valid && nxt_buy;
            sell_signal <= band.valid && nxt_sell;
            if (band.valid) begin
                out_ch          <= band.ch;
                pos_state       <= nxt_pos;
                pos_q[band.ch]  <= nxt_pos;
                cd_q[band.ch]   <= nxt_cd;
            end
        end
    end
endmodule
